// File: rtl/pdm_stereo_deserializer.sv
// PDM mic front end: clock-enable bit clock, mono/stereo MSB-first word assembly, show-ahead valid/ready FIFO (word visible 1 cycle after its tick).
// A full FIFO drops new words and sets sticky overrun_o; define PDM_DECIMATE_EN to push popcounts instead of raw bit words.
module pdm_stereo_deserializer #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int NUM_CHANNELS       = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  output logic                   pdm_clk_o,
  input  logic                   pdm_data_i,
  output logic                   pdm_lrsel_o,
  output logic [WORD_LENGTH-1:0] data_o,
  output logic                   channel_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o
);

  localparam int CLK_DIV  = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
  localparam int HALF_DIV = CLK_DIV / 2;
  localparam int DW       = $clog2(HALF_DIV);
  localparam int BW       = $clog2(WORD_LENGTH);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam bit STEREO   = (NUM_CHANNELS == 2);

  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_LENGTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_WRAP = {1'b1, {AW{1'b0}}};

  logic [DW-1:0]          div_cnt;
  logic                   pdm_clk;
  logic                   div_term, rise_tick, fall_tick;
  logic                   sync1, sync2;
  logic [WORD_LENGTH-2:0] sr0, sr1;
  logic [BW-1:0]          cnt0, cnt1;
  logic [WORD_LENGTH-1:0] word0, word1;
  logic                   done0, done1;
  logic                   push, push_ch, pop, full, wr_en;
  logic [WORD_LENGTH-1:0] push_dat;
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [WORD_LENGTH-1:0] mem_dat [FIFO_DEPTH];
  logic                   mem_ch  [FIFO_DEPTH];

  function automatic logic [WORD_LENGTH-1:0] shape(input logic [WORD_LENGTH-1:0] w);
`ifdef PDM_DECIMATE_EN
    logic [WORD_LENGTH-1:0] n;
    n = '0;
    for (int i = 0; i < WORD_LENGTH; i++) n = n + WORD_LENGTH'(w[i]);
    return n;
`else
    return w;
`endif
  endfunction

  assign pdm_lrsel_o = STEREO;
  assign pdm_clk_o   = pdm_clk;
  assign div_term    = (div_cnt == DIV_LAST);
  assign rise_tick   = enable_i && div_term && !pdm_clk;
  assign fall_tick   = enable_i && div_term && pdm_clk && STEREO;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!enable_i) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_term) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // The data line is asynchronous to clock_i; only sync2 is ever sampled.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_data_i;
      sync2 <= sync1;
    end
  end

  assign word0 = {sr0, sync2};
  assign word1 = {sr1, sync2};
  assign done0 = rise_tick && (cnt0 == BIT_LAST);
  assign done1 = fall_tick && (cnt1 == BIT_LAST);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sr0  <= '0;
      sr1  <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (!enable_i) begin
      sr0  <= '0;
      sr1  <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (rise_tick) begin
        sr0  <= word0[WORD_LENGTH-2:0];
        cnt0 <= done0 ? '0 : cnt0 + BIT_ONE;
      end
      if (fall_tick) begin
        sr1  <= word1[WORD_LENGTH-2:0];
        cnt1 <= done1 ? '0 : cnt1 + BIT_ONE;
      end
    end
  end

  // Rise and fall ticks never coincide, so at most one channel pushes per cycle.
  assign push     = done0 || done1;
  assign push_ch  = done1;
  assign push_dat = shape(done1 ? word1 : word0);
  assign full     = ((wr_ptr ^ rd_ptr) == PTR_WRAP);
  assign valid_o  = (wr_ptr != rd_ptr);
  assign pop      = valid_o && ready_i;
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_dat[wr_ptr[AW-1:0]] <= push_dat;
      mem_ch[wr_ptr[AW-1:0]]  <= push_ch;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
    end else if (!enable_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (push && full && !pop) overrun_o <= 1'b1;
    end
  end

  assign data_o    = valid_o ? mem_dat[rd_ptr[AW-1:0]] : '0;
  assign channel_o = valid_o ? mem_ch[rd_ptr[AW-1:0]] : 1'b0;

endmodule

// File: tb/tb_pdm_stereo_deserializer.sv
// Bench for pdm_stereo_deserializer: a mono and a stereo instance share stimulus; a queue-based model predicts words.
// Honours PDM_DECIMATE_EN the same way as the design.
module tb_pdm_stereo_deserializer;

  localparam int WL = 8;
`ifdef PDM_DECIMATE_EN
  localparam logic [7:0] ONES_W = 8'h08;
  localparam logic [7:0] ALT_W  = 8'h04;
`else
  localparam logic [7:0] ONES_W = 8'hFF;
  localparam logic [7:0] ALT_W  = 8'hAA;
`endif
  localparam logic [7:0] ZERO_W = 8'h00;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pdm_data = 1'b0, ready = 1'b0;
  logic m_pdm_clk, m_lrsel, m_ch, m_valid, m_ovr;
  logic s_pdm_clk, s_lrsel, s_ch, s_valid, s_ovr;
  logic [WL-1:0] m_data, s_data;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pdm_stereo_deserializer #(.WORD_LENGTH(WL), .SYSTEM_FREQUENCY(100000000),
    .SAMPLING_FREQUENCY(12500000), .NUM_CHANNELS(1), .FIFO_DEPTH(4)) dut_m (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .pdm_clk_o(m_pdm_clk),
    .pdm_data_i(pdm_data), .pdm_lrsel_o(m_lrsel), .data_o(m_data), .channel_o(m_ch),
    .valid_o(m_valid), .ready_i(ready), .overrun_o(m_ovr));

  pdm_stereo_deserializer #(.WORD_LENGTH(WL), .SYSTEM_FREQUENCY(100000000),
    .SAMPLING_FREQUENCY(12500000), .NUM_CHANNELS(2), .FIFO_DEPTH(4)) dut_s (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .pdm_clk_o(s_pdm_clk),
    .pdm_data_i(pdm_data), .pdm_lrsel_o(s_lrsel), .data_o(s_data), .channel_o(s_ch),
    .valid_o(s_valid), .ready_i(ready), .overrun_o(s_ovr));

  // Reference model: run_t counts cycles since enable; rise ticks at t%8==3, fall ticks at t%8==7.
  typedef struct packed {logic [7:0] d; logic c;} ent_t;
  ent_t mq0[$];
  ent_t mq1[$];
  int run_t = 0, cyc = 0, rel_cyc = 0;
  bit m_ovr0 = 0, m_ovr1 = 0;
  int wcnt [4];
  logic [7:0] wval [4];
  bit dlog [16384];

  function automatic logic [7:0] shape(input logic [7:0] v);
`ifdef PDM_DECIMATE_EN
    return 8'($countones(v));
`else
    return v;
`endif
  endfunction

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    m_ovr0 = 0;
    m_ovr1 = 0;
    run_t = 0;
    for (int i = 0; i < 4; i++) begin
      wcnt[i] = 0;
      wval[i] = 8'h00;
    end
  endtask

  // idx = instance*2 + channel
  task automatic add_bit(input int idx, input bit s);
    logic [7:0] w;
    wval[idx] = {wval[idx][6:0], s};
    wcnt[idx]++;
    if (wcnt[idx] == 8) begin
      w = shape(wval[idx]);
      if (idx < 2) begin
        if (mq0.size() == 4) m_ovr0 = 1;
        else mq0.push_back({w, 1'b0});
      end else begin
        if (mq1.size() == 4) m_ovr1 = 1;
        else mq1.push_back({w, idx == 3});
      end
      wcnt[idx] = 0;
      wval[idx] = 8'h00;
    end
  endtask

  always @(posedge rst_n) rel_cyc = cyc;

  always @(posedge clk or negedge rst_n) begin : model_b
    bit s;
    if (!rst_n) model_clear();
    else begin
      dlog[cyc % 16384] = pdm_data;
      if (!en) model_clear();
      else begin
        s = (cyc - 2 >= rel_cyc) ? dlog[(cyc - 2) % 16384] : 1'b0;
        if (mq0.size() > 0 && ready) void'(mq0.pop_front());
        if (mq1.size() > 0 && ready) void'(mq1.pop_front());
        if (run_t % 8 == 3) begin
          add_bit(0, s);
          add_bit(2, s);
        end
        if (run_t % 8 == 7) add_bit(3, s);
        run_t++;
      end
      cyc++;
    end
  end

  task automatic restart();
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; pdm_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m_pdm_clk, m_valid, m_ovr, m_ch, m_data} !== 12'h000) begin
      bad++; $display("FAIL reset_mono got=%h want=000", {m_pdm_clk, m_valid, m_ovr, m_ch, m_data});
    end
    total++;
    if ({s_pdm_clk, s_valid, s_ovr, s_ch, s_data} !== 12'h000) begin
      bad++; $display("FAIL reset_stereo got=%h want=000", {s_pdm_clk, s_valid, s_ovr, s_ch, s_data});
    end
    total++;
    if (m_lrsel !== 1'b0) begin bad++; $display("FAIL lrsel_mono got=%b want=0", m_lrsel); end
    total++;
    if (s_lrsel !== 1'b1) begin bad++; $display("FAIL lrsel_stereo got=%b want=1", s_lrsel); end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_mono_ones();
    int n = 0;
    pdm_data = 1'b1; ready = 1'b1;
    restart();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_valid) begin
        total++;
        if (m_data !== ONES_W || m_ch !== 1'b0) begin
          bad++; $display("FAIL ones_word got=%h/%b want=%h/0", m_data, m_ch, ONES_W);
        end
        total++;
        if (i != 60 + 64 * n) begin bad++; $display("FAIL ones_time got=%0d want=%0d", i, 60 + 64 * n); end
        n++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL ones_count got=%0d want=3", n); end
  endtask

  task automatic test_alternating();
    int n = 0;
    ready = 1'b1;
    restart();
    for (int i = 0; i < 200; i++) begin
      pdm_data = ((i / 8) % 2 == 0);
      @(negedge clk);
      if (m_valid) begin
        total++;
        if (m_data !== ALT_W) begin bad++; $display("FAIL alt_word got=%h want=%h", m_data, ALT_W); end
        n++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL alt_count got=%0d want=3", n); end
  endtask

  task automatic test_stereo();
    int n = 0;
    int exp_t;
    ready = 1'b1;
    restart();
    for (int i = 0; i < 200; i++) begin
      pdm_data = ((i % 8) < 4);
      @(negedge clk);
      if (s_valid) begin
        exp_t = 60 + 64 * (n / 2) + 4 * (n % 2);
        total++;
        if (s_ch !== 1'(n % 2) || s_data !== ((n % 2) ? ZERO_W : ONES_W) || i != exp_t) begin
          bad++;
          $display("FAIL stereo_entry got=%b/%h@%0d want=%0d/%h@%0d", s_ch, s_data, i,
                   n % 2, (n % 2) ? ZERO_W : ONES_W, exp_t);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (n != 6) begin bad++; $display("FAIL stereo_count got=%0d want=6", n); end
  endtask

  task automatic test_overrun();
    int n = 0;
    pdm_data = 1'b1; ready = 1'b0;
    restart();
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      if (i == 300) begin
        total++;
        if ({m_valid, m_ovr, m_data} !== {1'b1, 1'b0, ONES_W}) begin
          bad++; $display("FAIL ovr_full got=%b%b/%h want=10/%h", m_valid, m_ovr, m_data, ONES_W);
        end
      end
      if (i == 320) begin
        total++;
        if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", m_ovr); end
      end
      @(posedge clk); #1;
    end
    ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) begin
        n++;
        total++;
        if (m_data !== ONES_W) begin bad++; $display("FAIL ovr_drain got=%h want=%h", m_data, ONES_W); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL ovr_drain_count got=%0d want=4", n); end
    @(negedge clk);
    total++;
    if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", m_ovr); end
  endtask

  task automatic test_enable_blip();
    int first = -1;
    @(posedge clk); #1;
    while (run_t < 360) begin @(posedge clk); #1; end
    en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    total++;
    if ({m_pdm_clk, m_valid, m_ovr} !== 3'b000) begin
      bad++; $display("FAIL blip_clear got=%b want=000", {m_pdm_clk, m_valid, m_ovr});
    end
    total++;
    if ({s_pdm_clk, s_valid, s_ovr} !== 3'b000) begin
      bad++; $display("FAIL blip_clear_s got=%b want=000", {s_pdm_clk, s_valid, s_ovr});
    end
    for (int i = 2; i <= 100; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (m_valid && first < 0) begin
        first = i;
        total++;
        if (m_data !== ONES_W) begin bad++; $display("FAIL blip_word got=%h want=%h", m_data, ONES_W); end
      end
    end
    total++;
    if (first != 61) begin bad++; $display("FAIL blip_latency got=%0d want=61", first); end
  endtask

  task automatic test_async_reset();
    int first = -1;
    pdm_data = 1'b1; ready = 1'b0;
    restart();
    repeat (200) @(posedge clk);
    #1;
    total++;
    if (m_valid !== 1'b1) begin bad++; $display("FAIL areset_queued got=%b want=1", m_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({m_pdm_clk, m_valid, m_ovr, m_ch, m_data, s_pdm_clk, s_valid, s_ovr, s_ch, s_data} !== 24'h0) begin
      bad++; $display("FAIL areset_outputs got=%h want=0",
                      {m_pdm_clk, m_valid, m_ovr, m_ch, m_data, s_pdm_clk, s_valid, s_ovr, s_ch, s_data});
    end
    ready = 1'b1;
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (m_valid && first < 0) begin
        first = i;
        total++;
        if (m_data !== ONES_W || m_ch !== 1'b0) begin
          bad++; $display("FAIL areset_word got=%h/%b want=%h/0", m_data, m_ch, ONES_W);
        end
      end
    end
    total++;
    if (first != 60) begin bad++; $display("FAIL areset_latency got=%0d want=60", first); end
  endtask

  task automatic test_random();
    @(posedge clk); #1;
    for (int i = 0; i < 4000; i++) begin
      pdm_data = 1'($urandom % 2);
      ready = ((i % 1000) < 400) ? 1'b0 : ($urandom % 4 != 0);
      en = ($urandom % 600 != 0);
      @(negedge clk);
      total++;
      if ({m_valid, m_ovr, m_pdm_clk} !== {mq0.size() > 0, m_ovr0, (run_t % 8) >= 4}) begin
        bad++; $display("FAIL rand_mono_ctl cyc=%0d got=%b want=%b", i, {m_valid, m_ovr, m_pdm_clk},
                        {mq0.size() > 0, m_ovr0, (run_t % 8) >= 4});
      end
      if (mq0.size() > 0) begin
        total++;
        if ({m_ch, m_data} !== {mq0[0].c, mq0[0].d}) begin
          bad++; $display("FAIL rand_mono_head cyc=%0d got=%h want=%h", i, {m_ch, m_data}, {mq0[0].c, mq0[0].d});
        end
      end
      total++;
      if ({s_valid, s_ovr, s_pdm_clk} !== {mq1.size() > 0, m_ovr1, (run_t % 8) >= 4}) begin
        bad++; $display("FAIL rand_stereo_ctl cyc=%0d got=%b want=%b", i, {s_valid, s_ovr, s_pdm_clk},
                        {mq1.size() > 0, m_ovr1, (run_t % 8) >= 4});
      end
      if (mq1.size() > 0) begin
        total++;
        if ({s_ch, s_data} !== {mq1[0].c, mq1[0].d}) begin
          bad++; $display("FAIL rand_stereo_head cyc=%0d got=%h want=%h", i, {s_ch, s_data}, {mq1[0].c, mq1[0].d});
        end
      end
      @(posedge clk); #1;
    end
    en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mono_ones();
    test_alternating();
    test_stereo();
    test_overrun();
    test_enable_blip();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_stereo_deserializer.md
# pdm_stereo_deserializer

Parametrised PDM microphone front end that succeeds the single-channel deserializer. It generates the microphone bit clock from the system clock as a clock-enable tick, not a derived clock, so all logic runs in one clock domain. It captures one mono channel or two stereo channels interleaved on a shared data line, assembles each channel into MSB-first words, and queues them in a small output FIFO with a valid/ready handshake and overrun detection. It sits between the board's PDM microphone pins and the audio controller/filter chain.

## Interface
- WORD_LENGTH, 16, bits per output word; 2..32.
- SYSTEM_FREQUENCY, 100000000, clock_i frequency in Hz.
- SAMPLING_FREQUENCY, 1000000, PDM bit-clock frequency in Hz; CLK_DIV = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY must be even and at least 8.
- NUM_CHANNELS, 1, either 1 (mono, channel 0 only) or 2 (stereo).
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clock_i  in  1  system clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  run enable from the controller.
- pdm_clk_o  out  1  microphone bit clock.
- pdm_data_i  in  1  shared PDM data line (asynchronous).
- pdm_lrsel_o  out  1  L/R select: 0 when NUM_CHANNELS=1, 1 when NUM_CHANNELS=2.
- data_o  out  WORD_LENGTH  FIFO head word.
- channel_o  out  1  channel of the FIFO head word.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts the head word when valid_o && ready_i.
- overrun_o  out  1  sticky flag: a completed word was dropped.

## Operation
- **Reset** (reset_n_i low, asynchronous): every output is 0 (pdm_clk_o, data_o, channel_o, valid_o, overrun_o); divider count, shift registers, bit counters and FIFO pointers are 0. pdm_lrsel_o stays at its constant value.
- **enable_i low** (synchronous): same state as reset, except overrun_o is also cleared. The divider is held, so pdm_clk_o stays low.
- **Divider**
  - Counter runs 0..CLK_DIV/2-1. At the terminal count it wraps and pdm_clk_o toggles.
  - Rise tick: terminal count while pdm_clk_o=0.
  - Fall tick: terminal count while pdm_clk_o=1.
- **Input synchroniser:** pdm_data_i passes through a two-flop synchroniser. Every sample is taken from the synchroniser output.
- **Channel 0** samples on the rise tick.
- **Channel 1** (stereo only) samples on the fall tick. In mono the fall tick does nothing.
- **Word assembly, per channel:** independent shift register and bit counter. The first sample lands in bit WORD_LENGTH-1 (MSB-first). The WORD_LENGTH-th sample completes the word and resets the counter. Only complete words are ever emitted.
- **FIFO:** each completed word is pushed with its channel number. Channel 0 and channel 1 completions fall on different cycles, so there is never more than one push per cycle.
- **Full FIFO:** a push into a full FIFO with no pop in the same cycle discards the new word and sets overrun_o. Push and pop in the same cycle are accepted when full.
- **Head and pop:** data_o and channel_o present the head entry (show-ahead). A pop happens on valid_o && ready_i. data_o is don't-care while valid_o=0.

## Timing
- Word-completing tick in cycle T: the word is written at the end of T, and valid_o=1 from cycle T+1 if the FIFO was empty.
- Pop in cycle P: the next entry (or valid_o=0) appears in cycle P+1.
- Input-to-sample latency is 2 cycles. A sample reflects pdm_data_i as it was 2 cycles before the tick.
- First rise tick after enable_i rises: cycle CLK_DIV/2. Word period per channel: WORD_LENGTH*CLK_DIV cycles.
- enable_i low in cycle T: pdm_clk_o=0, valid_o=0 and FIFO empty from T+1. Partial words are lost.
- overrun_o is set in the cycle after the dropped push and holds until reset or enable_i low.

## Configuration
- PDM_DECIMATE_EN defined: each completed word is replaced, before the push, by its popcount (number of 1 samples, 0..WORD_LENGTH), zero-extended to WORD_LENGTH bits. Timing is unchanged.
- PDM_DECIMATE_EN undefined: the raw MSB-first bit word is pushed.

## Test plan
Common settings: WORD_LENGTH=8, SYSTEM_FREQUENCY=100000000, SAMPLING_FREQUENCY=12500000 (CLK_DIV=8).
1. Mono, pdm_data_i=1, ready_i=1 -> first word 0xFF with channel_o=0; after that, one word every 64 cycles. With PDM_DECIMATE_EN the word is 0x08.
2. Mono, pdm_data_i alternating 1,0 per pdm_clk_o period, starting 1 -> words 0xAA. With PDM_DECIMATE_EN the word is 0x04.
3. Stereo, pdm_data_i=1 while pdm_clk_o low and 0 while high -> alternating entries: channel 0 = 0xFF, channel 1 = 0x00, channel 0 first.
4. Mono, FIFO_DEPTH=4, ready_i=0, data 1 -> valid_o is held with 0xFF. The 5th word is dropped and overrun_o=1. Raising ready_i drains exactly 4 words; overrun_o stays 1.
5. enable_i low for 1 cycle mid-word, then high -> pdm_clk_o=0, valid_o=0 and overrun_o=0 next cycle. The next word needs a full 8 fresh samples (first tick at cycle 4).
6. reset_n_i pulsed low asynchronously between clock edges while words are queued -> all outputs 0 immediately. Operation restarts as in scenario 1 after release.
